// File: rtl/button_event_if.sv
// Event channel between the button edge arbiter and its consumer.
// Handshake: the master holds event_valid and event_id stable until a cycle
// where event_ready is also high; that cycle transfers exactly one event.
// The consumer may drive event_ready freely, and it may depend on event_valid.
interface button_event_if #(
   parameter int width    = 4,
   parameter int id_width = (width > 1) ? $clog2(width) : 1
);
   logic [width-1:0]    signal_in;
   logic                event_valid;
   logic [id_width-1:0] event_id;
   logic                event_ready;
   logic [width-1:0]    overflow;
   logic                clear_overflow;

   modport master (
      input  signal_in, event_ready, clear_overflow,
      output event_valid, event_id, overflow
   );

   modport slave (
      output signal_in, event_ready, clear_overflow,
      input  event_valid, event_id, overflow
   );
endinterface

// File: rtl/button_event_arbiter.sv
// Turns rising edges on debounced button levels into a stream of channel ids.
// Each edge sets a pending bit. A round-robin search grants one pending
// channel into a single registered output slot.
module button_event_arbiter #(
   parameter int width    = 4,
   parameter int id_width = (width > 1) ? $clog2(width) : 1
) (
   input logic          clk,
   input logic          rst_n,
   button_event_if.master bus
);

   logic [width-1:0]    prev;
   logic [width-1:0]    pending;
   logic [width-1:0]    overflow_r;
   logic                valid_r;
   logic [id_width-1:0] id_r;
   logic [id_width-1:0] last_grant;

   logic [width-1:0]    edge_det;
   logic [width-1:0]    grant_mask;
   logic [width-1:0]    overflow_set;
   logic [id_width-1:0] grant_idx;
   logic [id_width-1:0] cand;
   logic                grant_found;
   logic                slot_free;
   logic                grant;

   assign edge_det  = bus.signal_in & ~prev;
   assign slot_free = ~valid_r | bus.event_ready;
   assign grant     = slot_free & grant_found;

   // Round-robin search: walk from last_grant+1, wrap at width-1, end at last_grant.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = last_grant;
      for (int k = 0; k < width; k++) begin
         if (cand == id_width'(width - 1)) cand = '0;
         else                              cand = cand + id_width'(1);
         if (!grant_found && pending[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // One-hot mask of the channel being granted this cycle (zero if none).
   always_comb begin
      grant_mask = '0;
      if (grant) grant_mask[grant_idx] = 1'b1;
   end

   // An edge is lost only if its channel is still pending and not being granted now.
   assign overflow_set = edge_det & pending & ~grant_mask;

   // Previous-level register. It resets high so lines already up at reset stay silent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= '1;
      else        prev <= bus.signal_in;
   end

   // Pending and overflow bits. A new edge beats a grant, and an overflow set beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending    <= '0;
         overflow_r <= '0;
      end else begin
         pending <= (pending & ~grant_mask) | edge_det;
         if (bus.clear_overflow) overflow_r <= overflow_set;
         else                    overflow_r <= overflow_r | overflow_set;
      end
   end

   // Output slot: when free, load the granted channel or go idle; otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r    <= 1'b0;
         id_r       <= '0;
         last_grant <= id_width'(width - 1);
      end else if (slot_free) begin
         if (grant_found) begin
            valid_r    <= 1'b1;
            id_r       <= grant_idx;
            last_grant <= grant_idx;
         end else begin
            valid_r <= 1'b0;
         end
      end
   end

   assign bus.event_valid = valid_r;
   assign bus.event_id    = id_r;
   assign bus.overflow    = overflow_r;

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Collects rising edges from a bus of synchronized, debounced button/switch levels and serializes them onto one valid/ready event channel. Each channel captures its 0→1 transition into a pending bit. A round-robin arbiter grants pending channels one at a time to a single consumer, typically the CPU-facing MMIO FIFO. Sits between the button synchronizer/debouncer chain and the I/O memory map, replacing ad-hoc per-button pulse wiring.

## Interface
- `width`, default 4: number of input channels (≥1).
- `id_width`, default `max(1, clog2(width))`: width of `event_id`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `signal_in`  in  `width`  synchronized level inputs.
- `event_valid`  out  1  an event is presented on `event_id`.
- `event_id`  out  `id_width`  index of the channel whose edge is presented.
- `event_ready`  in  1  consumer accepts the event this cycle.
- `overflow`  out  `width`  sticky per-channel flag: an edge was lost.
- `clear_overflow`  in  1  single-cycle strobe; clears all `overflow` bits.

## Operation
- **Edge capture.**
  - `prev` register samples `signal_in` every cycle.
  - `edge[i] = signal_in[i] & ~prev[i]`.
  - `prev` resets to all ones, so a line that is high at reset release produces no event until it has gone low and then high again.
- **Pending.**
  - `pending[i]` sets on `edge[i]`.
  - `pending[i]` clears when channel i is granted.
  - If a set and a clear on the same channel fall in the same cycle, the set wins: the new edge stays pending.
- **Overflow.**
  - `overflow[i]` sets when `edge[i]` occurs while `pending[i]` is 1 and channel i is not being granted that cycle.
  - `clear_overflow` clears every bit. If an overflow set coincides with `clear_overflow`, the set wins.
  - The lost edge is dropped; `pending` stays 1 and only one event is produced.
- **Output slot.**
  - The slot is free when `event_valid` is 0 or when `event_valid & event_ready` is true.
  - When the slot is free and any `pending` bit is 1, grant the first pending channel in search order. Search starts at `last_grant+1`, wraps modulo `width`, and ends at `last_grant`.
  - On grant, load `event_id`, set `event_valid` to 1, clear that pending bit, and update `last_grant`.
  - When the slot is free and nothing is pending, `event_valid` goes to 0.
- **Stall.**
  - While `event_valid & ~event_ready`, `event_id` and `event_valid` hold stable and no grant occurs.
  - New edges continue to accumulate into `pending` during a stall.
- **`width=1`.** The arbiter degenerates: `event_id` is constantly 0.

## Timing
- **Reset values:**
  - `event_valid` = 0
  - `event_id` = 0
  - `overflow` = 0
  - `pending` = 0
  - `prev` = all ones
  - `last_grant` = `width-1`, so channel 0 has first priority.
- **Latency.** If `signal_in[i]` rises at cycle N (`prev` = 0), then `pending[i]` = 1 at N+1. With the slot free, `event_valid` = 1 with `event_id` = i at N+2.
- **Throughput.** One event per cycle when `event_ready` is held high and multiple channels are pending.
- **Back-to-back.** A handshake at cycle K and a grant at K load the next event, visible at K+1, with no bubble.
- **Mid-operation reset.** Asserting `rst_n` low forces all state to its reset values immediately, regardless of `clk`. A presented event is discarded without handshake. After deassertion, channels that are currently high produce no events.
- **Outputs.** All outputs are registered; there is no combinational path from `signal_in` or `event_ready` to any output.

## Test plan
- **Single edge.** Reset, hold `signal_in`=0 for 3 cycles, raise bit 2 at cycle N, `event_ready`=1 → `event_valid`=1 and `event_id`=2 at exactly N+2 for one cycle only, `overflow`=0.
- **Reset-high suppression.** `signal_in`=4'b1111 during and after reset for 10 cycles → `event_valid` stays 0. Then drop bit 1 and raise it again → exactly one event with id 1.
- **Round robin.** Raise bits 0,1,3 in the same cycle with `event_ready`=1 → ids 0,1,3 on consecutive cycles. Repeat the edges → order 0,1,3 again, since search starts after 3.
- **Stall.** Produce an event on id 1, hold `event_ready`=0 for 5 cycles → `event_id` stays 1 and `event_valid` stays 1. An edge on bit 3 during the stall is presented immediately after the handshake.
- **Overflow.** With `event_ready`=0, make two rising edges on bit 2 while the slot holds id 0 → `overflow[2]`=1 and only one id-2 event appears after release. Pulse `clear_overflow` → `overflow`=0. Repeat with an overflow on the same cycle as `clear_overflow` → `overflow[2]` remains 1.
- **Async reset.** Assert `rst_n`=0 mid-cycle while `event_valid`=1 → `event_valid`=0 before the next `clk` edge, with `pending` and `overflow` cleared.
